// File: rtl/piso_tx_if.sv
// Parallel-in/serial-out handshake bundle: load/word toward the shifter, serial stream back.
// The master drives load and parallel_in. The slave returns ready and the serial outputs.
interface piso_tx_if #(
    parameter int WIDTH = 4
);
    logic             load;
    logic [WIDTH-1:0] parallel_in;
    logic             ready;
    logic             serial_out;
    logic             serial_valid;
    logic             done;

    modport master (
        output load,
        output parallel_in,
        input  ready,
        input  serial_out,
        input  serial_valid,
        input  done
    );

    modport slave (
        input  load,
        input  parallel_in,
        output ready,
        output serial_out,
        output serial_valid,
        output done
    );
endinterface

// File: rtl/piso_tx.sv
// Word serializer: first bit one cycle after accept, one bit per clock, all outputs registered.
// ready drops while a word is in flight and rises again in its final-bit cycle, so words can run back-to-back.
module piso_tx #(
    parameter int WIDTH     = 4,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    piso_tx_if.slave    bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             ready_q, ready_d;
    logic             sout_q, sout_d;
    logic             svld_q, svld_d;
    logic             done_q, done_d;

    logic             accept;
    logic             last_bit;
    logic [WIDTH-1:0] shreg_shifted;

    assign accept   = bus.load && ready_q;
    assign last_bit = (state_q == SHIFT) && (cnt_q == LAST_IDX);

    // The presented bit always sits at the outgoing end of the register.
    assign shreg_shifted = MSB_FIRST ? {shreg_q[WIDTH-2:0], 1'b0}
                                     : {1'b0, shreg_q[WIDTH-1:1]};

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;

        if (accept) begin
            state_d = SHIFT;
            shreg_d = bus.parallel_in;
            cnt_d   = '0;
        end else if (state_q == SHIFT) begin
            if (last_bit) begin
                state_d = IDLE;
                shreg_d = '0;
                cnt_d   = '0;
            end else begin
                shreg_d = shreg_shifted;
                cnt_d   = cnt_q + CW'(1);
            end
        end

        // Outputs are precomputed from the next state so they can be flopped.
        svld_d  = (state_d == SHIFT);
        sout_d  = svld_d && (MSB_FIRST ? shreg_d[WIDTH-1] : shreg_d[0]);
        done_d  = svld_d && (cnt_d == LAST_IDX);
        ready_d = !svld_d || (cnt_d == LAST_IDX);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            sout_q  <= 1'b0;
            svld_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            sout_q  <= sout_d;
            svld_q  <= svld_d;
            done_q  <= done_d;
        end
    end

    assign bus.ready        = ready_q;
    assign bus.serial_out   = sout_q;
    assign bus.serial_valid = svld_q;
    assign bus.done         = done_q;
endmodule

// File: doc/piso_tx.md
PISO_TX -- requirements
Module: piso_tx

Interface
REQ-001 Parameter WIDTH, default 4: parallel word width in bits, legal range 2..32.
REQ-002 Parameter MSB_FIRST, default 1: 1 shifts MSB first, 0 shifts LSB first.
REQ-003 Port clk, input, 1: single clock, all state updates on rising edge.
REQ-004 Port rst, input, 1: synchronous, active-high reset.
REQ-005 Port load, input, 1: request to transmit parallel_in.
REQ-006 Port parallel_in, input, WIDTH: word to serialize, sampled only on accept.
REQ-007 Port ready, output, 1: block can accept a word this cycle.
REQ-008 Port serial_out, output, 1: current serial bit.
REQ-009 Port serial_valid, output, 1: serial_out carries a valid frame bit this cycle.
REQ-010 Port done, output, 1: last bit of the current word is on serial_out this cycle.

Function
REQ-011 The block SHALL implement a two-state FSM: IDLE and SHIFT.
REQ-012 Accept SHALL occur on a rising edge where load=1 and ready=1; parallel_in is captured into an internal WIDTH-bit shift register at that edge.
REQ-013 IDLE->SHIFT on accept; SHIFT->IDLE after the last bit unless a new accept occurs on that same edge; SHIFT->SHIFT otherwise.
REQ-014 Latency: the first bit SHALL appear on serial_out in the cycle immediately after the accept edge, with serial_valid=1.
REQ-015 Each bit SHALL be held for exactly one clock; a word occupies exactly WIDTH consecutive cycles.
REQ-016 Bit order: MSB_FIRST=1 sends parallel_in[WIDTH-1] down to [0]; MSB_FIRST=0 sends [0] up to [WIDTH-1].
REQ-017 A bit counter of ceil(log2(WIDTH)) bits SHALL track position; it SHALL be reset to 0 at each accept and shall not wrap mid-word.
REQ-018 done SHALL be 1 exactly in the cycle the final bit is presented, 0 in all other cycles.
REQ-019 ready SHALL be 1 in IDLE and in the final-bit cycle of SHIFT, 0 in all other SHIFT cycles.
REQ-020 Back-to-back: an accept in the final-bit cycle SHALL start the next word in the following cycle with no gap (serial_valid stays 1).
REQ-021 load asserted while ready=0 SHALL be ignored with no effect on state, data or outputs; it is not queued.
REQ-022 When serial_valid=0, serial_out SHALL be driven 0.
REQ-023 parallel_in changes outside an accept edge SHALL not affect the word in flight.

Reset
REQ-024 While rst=1 at a rising edge, the FSM SHALL go to IDLE, shift register and counter to 0; rst has priority over load.
REQ-025 Outputs after reset: ready=1, serial_out=0, serial_valid=0, done=0.
REQ-026 Reset asserted mid-word SHALL abort the word; remaining bits are never sent, and the next accepted word starts fresh from bit 0.

Verification
REQ-027 WIDTH=4, MSB_FIRST=1, load 4'b1010 for one cycle from IDLE -> serial_out 1,0,1,0 on the next four cycles with serial_valid=1; done=1 only on the 4th; ready=0 on cycles 1-3.
REQ-028 WIDTH=4, MSB_FIRST=0, load 4'b1101 -> serial_out 1,0,1,1; then serial_valid=0 and serial_out=0.
REQ-029 Back-to-back: 4'b1010 accepted, then 4'b0110 accepted in the done cycle -> eight contiguous valid bits 1,0,1,0,0,1,1,0; done pulses on bits 4 and 8.
REQ-030 Busy load: 4'b1010 accepted, then load=1 with 4'b1111 on bit cycle 2 only -> stream unchanged 1,0,1,0; block returns to IDLE with no second word.
REQ-031 Reset mid-word: rst=1 for one edge during bit 2 of 4'b1010 -> next cycle serial_valid=0, serial_out=0, ready=1, done=0; a subsequent load of 4'b0011 yields 0,0,1,1.
REQ-032 Continuous load=1 with parallel_in held at 4'b1001 for 12 cycles -> repeating stream 1,0,0,1 with no gaps; done every 4th bit.
